// File: rtl/aes128_req_arbiter.sv
// Round-robin two-channel job arbiter and sequencer for the shared AES-128 core.
// Optional WAIT-state abort enabled by defining AES128_ARB_TIMEOUT_EN.
module aes128_req_arbiter #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [127:0] req0_key,
  input  logic [127:0] req1_key,
  input  logic [127:0] req0_block,
  input  logic [127:0] req1_block,
  output logic [1:0]   rsp_valid,
  input  logic [1:0]   rsp_ready,
  output logic [127:0] rsp_data,
  output logic         rsp_err,
  output logic         busy,
  output logic         core_start,
  output logic [127:0] core_key,
  output logic [127:0] core_block,
  input  logic         core_done,
  input  logic [127:0] core_result
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t state;
  logic   last_grant;
  logic   grant;
  logic   sel;
  logic   accept;
  logic   timeout;

  // A tie goes to the channel that did not win last time.
  always_comb begin
    sel = 1'b0;
    if (req_valid == 2'b11) sel = ~last_grant;
    else                    sel = req_valid[1];
  end

  assign accept    = (state == IDLE) && (|req_valid) && !rst;
  assign req_ready = accept ? (sel ? 2'b10 : 2'b01) : 2'b00;

`ifdef AES128_ARB_TIMEOUT_EN
  localparam int CLOG = $clog2(TIMEOUT_CYC + 1);
  localparam int CW   = (CLOG > 5) ? CLOG : 5;

  logic [CW-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst || state != WAIT) wait_cnt <= '0;
    else                      wait_cnt <= wait_cnt + 1'b1;
  end

  assign timeout = (wait_cnt == CW'(TIMEOUT_CYC - 1));
`else
  assign timeout = (TIMEOUT_CYC < 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      rsp_valid  <= 2'b00;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      busy       <= 1'b0;
      core_start <= 1'b0;
      core_key   <= '0;
      core_block <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            grant      <= sel;
            core_key   <= sel ? req1_key : req0_key;
            core_block <= sel ? req1_block : req0_block;
            core_start <= 1'b1;
            busy       <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          core_start <= 1'b0;
          state      <= WAIT;
        end
        WAIT: begin
          if (core_done) begin
            rsp_data  <= core_result;
            rsp_err   <= 1'b0;
            rsp_valid <= grant ? 2'b10 : 2'b01;
            state     <= RESP;
          end else if (timeout) begin
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= grant ? 2'b10 : 2'b01;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready[grant]) begin
            last_grant <= grant;
            rsp_valid  <= 2'b00;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_req_arbiter.sv
// Randomized bench for aes128_req_arbiter with a transaction-level model
// of grant order, job latency and a stand-in AES core.
module tb_aes128_req_arbiter;

  localparam logic [127:0] FK = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FB = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   req_valid = 2'b00;
  logic [1:0]   req_ready;
  logic [127:0] req0_key = '0, req1_key = '0;
  logic [127:0] req0_block = '0, req1_block = '0;
  logic [1:0]   rsp_valid;
  logic [1:0]   rsp_ready = 2'b00;
  logic [127:0] rsp_data;
  logic         rsp_err;
  logic         busy;
  logic         core_start;
  logic [127:0] core_key, core_block;
  logic         core_done;
  logic [127:0] core_result;

  int n_chk  = 0;
  int n_fail = 0;

  logic [127:0] key_m [2];
  logic [127:0] blk_m [2];
  logic         model_last = 1'b1;

  logic [10:0]  pipe;
  logic [127:0] res_q;
  logic         core_en = 1'b1;
  logic         stray = 1'b0;

  always #5 clk = ~clk;

  aes128_req_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_key(req0_key), .req1_key(req1_key),
    .req0_block(req0_block), .req1_block(req1_block),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .core_start(core_start), .core_key(core_key),
    .core_block(core_block), .core_done(core_done),
    .core_result(core_result)
  );

  function automatic logic [127:0] fake_aes(input logic [127:0] k,
                                            input logic [127:0] b);
    if (k == FK && b == FB) return FC;
    return k ^ {b[63:0], b[127:64]} ^ 128'h5a5a_0f0f_3c3c_a5a5_5a5a_0f0f_3c3c_a5a5;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Stand-in core: done 11 cycles after start is sampled, reset with rst.
  always @(posedge clk) begin
    if (rst) pipe <= '0;
    else begin
      pipe <= {pipe[9:0], core_start};
      if (core_start) res_q <= fake_aes(core_key, core_block);
    end
  end
  assign core_done   = (pipe[10] & core_en) | stray;
  assign core_result = res_q;

  task automatic drive();
    req0_key = key_m[0]; req0_block = blk_m[0];
    req1_key = key_m[1]; req1_block = blk_m[1];
  endtask

  task automatic run_job(input logic [1:0] add, input int delay,
                         output logic g, output logic [127:0] got);
    logic [1:0]   oh;
    logic [127:0] exp_res;
    for (int c = 0; c < 2; c++)
      if (add[c] && !req_valid[c]) begin
        key_m[c] = rnd128();
        blk_m[c] = rnd128();
      end
    req_valid = req_valid | add;
    drive();
    #1;
    g = (req_valid == 2'b11) ? ~model_last : req_valid[1];
    oh = g ? 2'b10 : 2'b01;
    exp_res = fake_aes(key_m[g], blk_m[g]);
    n_chk++;
    if (req_ready !== oh || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL accept: req_ready=%b busy=%b, want %b 0",
               req_ready, busy, oh);
    end
    @(negedge clk);
    req_valid[g] = 1'b0;
    #1;
    n_chk++;
    if (core_start !== 1'b1 || req_ready !== 2'b00 ||
        core_key !== key_m[g] || core_block !== blk_m[g]) begin
      n_fail++;
      $display("FAIL issue: start=%b ready=%b key=%h, want 1 00 %h",
               core_start, req_ready, core_key, key_m[g]);
    end
    for (int i = 2; i <= 12; i++) begin
      @(negedge clk); #1;
      n_chk++;
      if (rsp_valid !== 2'b00 || core_start !== 1'b0 ||
          req_ready !== 2'b00 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL wait T+%0d: vld=%b start=%b ready=%b busy=%b, want 00 0 00 1",
                 i, rsp_valid, core_start, req_ready, busy);
      end
    end
    @(negedge clk); #1;
    n_chk++;
    if (rsp_valid !== oh || rsp_data !== exp_res ||
        rsp_err !== 1'b0 || req_ready !== 2'b00) begin
      n_fail++;
      $display("FAIL resp: vld=%b data=%h err=%b ready=%b, want %b %h 0 00",
               rsp_valid, rsp_data, rsp_err, req_ready, oh, exp_res);
    end
    got = rsp_data;
    for (int d = 0; d < delay; d++) begin
      rsp_ready = $urandom_range(0, 1) ? ~oh : 2'b00;
      @(negedge clk); #1;
      n_chk++;
      if (rsp_valid !== oh || rsp_data !== exp_res ||
          req_ready !== 2'b00 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL hold %0d: vld=%b data=%h ready=%b busy=%b, want %b %h 00 1",
                 d, rsp_valid, rsp_data, req_ready, busy, oh, exp_res);
      end
    end
    rsp_ready = oh | ($urandom_range(0, 1) ? ~oh : 2'b00);
    @(negedge clk);
    rsp_ready = 2'b00;
    model_last = g;
    #1;
    n_chk++;
    if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL release: vld=%b busy=%b, want 00 0", rsp_valid, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_chk++;
    if ({req_ready, rsp_valid, rsp_err, busy, core_start} !== 7'd0 ||
        rsp_data !== '0 || core_key !== '0 || core_block !== '0) begin
      n_fail++;
      $display("FAIL reset: ready=%b vld=%b err=%b busy=%b start=%b data=%h, want all 0",
               req_ready, rsp_valid, rsp_err, busy, core_start, rsp_data);
    end
    rst = 1'b0;
    model_last = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic         g;
    logic [127:0] got;
    key_m[0] = FK;
    blk_m[0] = FB;
    req_valid = 2'b01;
    run_job(2'b00, 0, g, got);
    n_chk++;
    if (g !== 1'b0 || got !== FC) begin
      n_fail++;
      $display("FAIL fips: grant=%b data=%h, want 0 %h", g, got, FC);
    end
  endtask

  task automatic test_fairness();
    logic         g;
    logic [127:0] got;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_last = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_job(2'b11, 0, g, got);
      n_chk++;
      if (g !== 1'(i % 2)) begin
        n_fail++;
        $display("FAIL fair job %0d: grant=%b, want %0d", i, g, i % 2);
      end
    end
    run_job(2'b00, 0, g, got);
  endtask

  task automatic test_stall();
    logic         g, g2;
    logic [127:0] got;
    run_job(2'b11, 20, g, got);
    n_chk++;
    if (req_valid[~g] !== 1'b1) begin
      n_fail++;
      $display("FAIL stall: other valid=%b, want 1", req_valid[~g]);
    end
    run_job(2'b00, 0, g2, got);
    n_chk++;
    if (g2 !== ~g) begin
      n_fail++;
      $display("FAIL stall drain: grant=%b, want %b", g2, ~g);
    end
  endtask

  task automatic test_random();
    logic         g;
    logic [127:0] got;
    logic [1:0]   add;
    for (int j = 0; j < 20; j++) begin
      add = 2'($urandom_range(0, 3));
      if (req_valid == 2'b00 && add == 2'b00) add = 2'b10;
      run_job(add, $urandom_range(0, 3), g, got);
      if (req_valid == 2'b00)
        repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    while (req_valid != 2'b00) run_job(2'b00, 0, g, got);
  endtask

  task automatic test_mid_reset();
    key_m[0] = rnd128();
    blk_m[0] = rnd128();
    drive();
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_last = 1'b1;
    #1;
    n_chk++;
    if ({req_ready, rsp_valid, rsp_err, busy, core_start} !== 7'd0 ||
        rsp_data !== '0 || core_key !== '0 || core_block !== '0) begin
      n_fail++;
      $display("FAIL mid reset: ready=%b vld=%b err=%b busy=%b start=%b key=%h, want all 0",
               req_ready, rsp_valid, rsp_err, busy, core_start, core_key);
    end
    for (int i = 0; i < 12; i++) begin
      stray = (i == 8);
      @(negedge clk); #1;
      n_chk++;
      if (rsp_valid !== 2'b00 || busy !== 1'b0 || core_start !== 1'b0) begin
        n_fail++;
        $display("FAIL after reset %0d: vld=%b busy=%b start=%b, want 00 0 0",
                 i, rsp_valid, busy, core_start);
      end
    end
    stray = 1'b0;
  endtask

  task automatic test_spurious_done();
    logic         g;
    logic [127:0] got;
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_chk++;
      if (rsp_valid !== 2'b00 || busy !== 1'b0 || rsp_data !== got) begin
        if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
          n_fail++;
          $display("FAIL spurious %0d: vld=%b busy=%b, want 00 0",
                   i, rsp_valid, busy);
        end
      end
    end
    run_job(2'b01, 1, g, got);
  endtask

  task automatic test_no_done();
    key_m[1] = rnd128();
    blk_m[1] = rnd128();
    drive();
    core_en = 1'b0;
    req_valid = 2'b10;
    #1;
    n_chk++;
    if (req_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL nodone accept: ready=%b, want 10", req_ready);
    end
    @(negedge clk);
    req_valid = 2'b00;
`ifdef AES128_ARB_TIMEOUT_EN
    for (int i = 1; i <= 17; i++) begin
      #1;
      n_chk++;
      if (rsp_valid !== 2'b00 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL timeout early T+%0d: vld=%b busy=%b, want 00 1",
                 i, rsp_valid, busy);
      end
      @(negedge clk);
    end
    #1;
    n_chk++;
    if (rsp_valid !== 2'b10 || rsp_err !== 1'b1 || rsp_data !== '0) begin
      n_fail++;
      $display("FAIL timeout resp: vld=%b err=%b data=%h, want 10 1 0",
               rsp_valid, rsp_err, rsp_data);
    end
    rsp_ready = 2'b10;
    @(negedge clk);
    rsp_ready = 2'b00;
    model_last = 1'b1;
`else
    for (int i = 1; i <= 100; i++) begin
      #1;
      n_chk++;
      if (rsp_valid !== 2'b00 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL no timeout T+%0d: vld=%b busy=%b, want 00 1",
                 i, rsp_valid, busy);
      end
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_last = 1'b1;
`endif
    core_en = 1'b1;
    #1;
    n_chk++;
    if (busy !== 1'b0 || rsp_valid !== 2'b00) begin
      n_fail++;
      $display("FAIL nodone recover: busy=%b vld=%b, want 0 00", busy, rsp_valid);
    end
    @(negedge clk);
  endtask

  initial begin
    key_m[0] = '0; key_m[1] = '0;
    blk_m[0] = '0; blk_m[1] = '0;
    test_reset();
    test_single();
    test_fairness();
    test_stall();
    test_random();
    test_mid_reset();
    test_spurious_done();
    test_no_done();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
